// File: rtl/pulser_pkg.sv
// Shared encodings for the multi-channel pulser: the mode selector and the
// per-channel auto-repeat FSM state.
package pulser_pkg;

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_RPT  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        RPT  = 2'b10
    } chan_state_e;

endpackage

// File: rtl/pulser_channel.sv
// One pulser channel: 2-flop synchroniser, debounce counter, edge/auto-repeat FSM.
//   state | meaning
//   IDLE  | no repeat in progress; waiting for a debounced rise (mode 11)
//   HOLD  | initial pulse issued; counting towards the first repeat
//   RPT   | repeating every RPT_CYCLES while held stays high
module pulser_channel
    import pulser_pkg::*;
#(
    parameter int DB_CYCLES   = 8,
    parameter int HOLD_CYCLES = 64,
    parameter int RPT_CYCLES  = 16
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  in_pulse,
    input  mode_e mode,
    input  logic  enable,
    output logic  out_pulse,
    output logic  held
);

    localparam int DBW  = $clog2(DB_CYCLES + 1);
    localparam int RMAX = (HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES;
    localparam int RW   = $clog2(RMAX);

    logic           sync1;
    logic           sync2;
    logic [DBW-1:0] db_cnt;
    logic           toggle;
    logic           rise;
    logic           fall;

    chan_state_e    state;
    chan_state_e    state_nxt;
    logic [RW-1:0]  rpt_cnt;
    logic [RW-1:0]  rpt_cnt_nxt;
    logic           pulse_nxt;

    // held flips on the same edge the counter would reach DB_CYCLES
    assign toggle = (sync2 != held) && (db_cnt == DBW'(DB_CYCLES - 1));
    assign rise   = toggle & ~held;
    assign fall   = toggle & held;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            db_cnt    <= '0;
            held      <= 1'b0;
            state     <= IDLE;
            rpt_cnt   <= '0;
            out_pulse <= 1'b0;
        end else begin
            sync1 <= in_pulse;
            sync2 <= sync1;
            if (sync2 == held || toggle) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            if (toggle) begin
                held <= ~held;
            end
            state     <= state_nxt;
            rpt_cnt   <= rpt_cnt_nxt;
            out_pulse <= pulse_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rpt_cnt_nxt = rpt_cnt + 1'b1;
        pulse_nxt   = 1'b0;
        if (!enable) begin
            state_nxt   = IDLE;
            rpt_cnt_nxt = '0;
        end else if (mode != MODE_RPT) begin
            state_nxt   = IDLE;
            rpt_cnt_nxt = '0;
            case (mode)
                MODE_RISE: pulse_nxt = rise;
                MODE_FALL: pulse_nxt = fall;
                MODE_BOTH: pulse_nxt = toggle;
                default:   pulse_nxt = 1'b0;
            endcase
        end else if (fall) begin
            // a fall beats any coincident terminal count
            state_nxt   = IDLE;
            rpt_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    rpt_cnt_nxt = '0;
                    if (rise) begin
                        pulse_nxt = 1'b1;
                        state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    if (rpt_cnt == RW'(HOLD_CYCLES - 1)) begin
                        pulse_nxt   = 1'b1;
                        rpt_cnt_nxt = '0;
                        state_nxt   = RPT;
                    end
                end
                RPT: begin
                    if (rpt_cnt == RW'(RPT_CYCLES - 1)) begin
                        pulse_nxt   = 1'b1;
                        rpt_cnt_nxt = '0;
                    end
                end
                default: begin
                    state_nxt   = IDLE;
                    rpt_cnt_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multi_channel_pulser.sv
// Multi-channel debounced edge pulser with optional auto-repeat; one
// independent pulser_channel per input bit, all sharing mode and enable.
module multi_channel_pulser
    import pulser_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int DB_CYCLES   = 8,
    parameter int HOLD_CYCLES = 64,
    parameter int RPT_CYCLES  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in_pulse,
    input  logic [1:0]          mode,
    input  logic                enable,
    output logic [CHANNELS-1:0] out_pulse,
    output logic [CHANNELS-1:0] held
);

    mode_e mode_sel;
    assign mode_sel = mode_e'(mode);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pulser_channel #(
            .DB_CYCLES  (DB_CYCLES),
            .HOLD_CYCLES(HOLD_CYCLES),
            .RPT_CYCLES (RPT_CYCLES)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .in_pulse (in_pulse[i]),
            .mode     (mode_sel),
            .enable   (enable),
            .out_pulse(out_pulse[i]),
            .held     (held[i])
        );
    end

endmodule

// File: tb/tb_multi_channel_pulser.sv
// Bench for multi_channel_pulser: directed timing scenarios plus randomized
// traffic, all compared every cycle against a window-based reference model.
module tb_multi_channel_pulser;

    localparam int CH   = 4;
    localparam int DB   = 8;
    localparam int HOLD = 64;
    localparam int RPT  = 16;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          enable   = 1'b1;
    logic [1:0]    mode     = 2'b00;
    logic [CH-1:0] in_pulse = '0;
    logic [CH-1:0] out_pulse;
    logic [CH-1:0] held;

    multi_channel_pulser #(
        .CHANNELS   (CH),
        .DB_CYCLES  (DB),
        .HOLD_CYCLES(HOLD),
        .RPT_CYCLES (RPT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_pulse (in_pulse),
        .mode     (mode),
        .enable   (enable),
        .out_pulse(out_pulse),
        .held     (held)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int passes   = 0;
    int n        = -1;
    int last_rst = 0;

    // model: samp[k] is the raw level sampled at edge k (zeroed where reset
    // flushed the synchroniser); repeat timing is arithmetic on the rise edge
    logic [CH-1:0] samp [$];
    logic [CH-1:0] m_held  = '0;
    logic [CH-1:0] m_pulse = '0;
    logic [CH-1:0] m_armed = '0;
    int            t0 [CH];

    int got [$];
    int exp_q [$];
    int held_rise;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic model_edge();
        logic tog;
        logic rs;
        logic fl;
        int   d;
        if (rst) begin
            samp.push_back('0);
            if (samp.size() > 1) samp[samp.size()-2] = '0;
            m_held   = '0;
            m_pulse  = '0;
            m_armed  = '0;
            last_rst = n;
        end else begin
            samp.push_back(in_pulse);
            for (int c = 0; c < CH; c++) begin
                tog = (n >= last_rst + DB) && (n - DB - 1 >= 0);
                if (tog) begin
                    for (int k = n - DB - 1; k <= n - 2; k++)
                        if (samp[k][c] == m_held[c]) tog = 1'b0;
                end
                rs = tog & ~m_held[c];
                fl = tog & m_held[c];
                if (tog) m_held[c] = ~m_held[c];
                m_pulse[c] = 1'b0;
                if (!enable || mode != 2'b11) begin
                    m_armed[c] = 1'b0;
                    if (enable)
                        m_pulse[c] = (mode == 2'b00) ? rs : (mode == 2'b01) ? fl : tog;
                end else if (fl) begin
                    m_armed[c] = 1'b0;
                end else if (rs) begin
                    m_pulse[c] = 1'b1;
                    m_armed[c] = 1'b1;
                    t0[c]      = n;
                end else if (m_armed[c]) begin
                    d = n - t0[c];
                    m_pulse[c] = (d == HOLD) || (d > HOLD && ((d - HOLD) % RPT) == 0);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        n++;
        model_edge();
        #1;
        check("out_pulse", 32'(out_pulse), 32'(m_pulse));
        check("held", 32'(held), 32'(m_held));
    endtask

    task automatic settle(input int k);
        rst      = 1'b0;
        enable   = 1'b1;
        in_pulse = '0;
        for (int i = 0; i < k; i++) step();
    endtask

    // cycle c of a scenario is the interval after edge base+c; pulses are
    // logged by the cycle index in which they are observed
    task automatic scenario(input int ch, input logic [1:0] md, input int hi_len,
                            input int total, input int rst_at,
                            input int en_lo_from, input int en_lo_to);
        got.delete();
        held_rise = -1;
        mode = md;
        for (int c = 0; c < total; c++) begin
            in_pulse[ch] = (c < hi_len);
            rst          = (c == rst_at);
            enable       = !(c >= en_lo_from && c <= en_lo_to);
            step();
            if (out_pulse[ch]) got.push_back(c + 1);
            if (held[ch] && held_rise < 0) held_rise = c + 1;
        end
        rst      = 1'b0;
        enable   = 1'b1;
        in_pulse = '0;
    endtask

    task automatic cmp_list(input string tag);
        int m;
        check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < m; i++)
            check({tag, "_cycle"}, 32'(got[i]), 32'(exp_q[i]));
    endtask

    initial begin
        int rate;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        settle(20);

        // rising mode, clean press
        scenario(0, 2'b00, 1000, 30, -1, -1, -1);
        exp_q = '{10};
        cmp_list("rise_ch0");
        check("rise_ch0_held_at", 32'(held_rise), 32'd10);
        settle(30);

        // short glitch is rejected
        scenario(1, 2'b00, 5, 30, -1, -1, -1);
        exp_q.delete();
        cmp_list("glitch_ch1");
        check("glitch_ch1_held", 32'(held_rise), 32'hFFFF_FFFF);
        settle(20);

        // both edges
        scenario(2, 2'b10, 30, 60, -1, -1, -1);
        exp_q = '{10, 40};
        cmp_list("both_ch2");
        settle(20);

        // auto-repeat
        scenario(3, 2'b11, 200, 250, -1, -1, -1);
        exp_q = '{10, 74};
        for (int t = 90; t <= 202; t += RPT) exp_q.push_back(t);
        cmp_list("rpt_ch3");
        settle(20);

        // auto-repeat with a reset pulse mid-hold
        scenario(3, 2'b11, 200, 250, 40, -1, -1);
        exp_q = '{10, 51, 115};
        for (int t = 131; t < 210; t += RPT) exp_q.push_back(t);
        cmp_list("rpt_rst_ch3");
        settle(20);

        // auto-repeat with enable dropped mid-repeat
        scenario(3, 2'b11, 200, 250, -1, 80, 120);
        exp_q = '{10, 74};
        cmp_list("rpt_en_ch3");
        settle(20);

        // randomized traffic in segments of varying input activity
        for (int seg = 0; seg < 16; seg++) begin
            mode = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       rate = 3;
                1:       rate = 20;
                default: rate = 150;
            endcase
            for (int i = 0; i < 200; i++) begin
                for (int c = 0; c < CH; c++)
                    if ($urandom_range(0, rate) == 0) in_pulse[c] = ~in_pulse[c];
                if ($urandom_range(0, 99) == 0) enable = ~enable;
                rst = ($urandom_range(0, 499) == 0);
                if ($urandom_range(0, 299) == 0) mode = 2'($urandom_range(0, 3));
                step();
            end
        end
        settle(20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
